// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the board-level reset sequencer.
// Imported by reset_sequencer and debounce.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } reset_seq_state_t;

    localparam int RESET_SEQ_DEBOUNCE_DEFAULT    = 65536;
    localparam int RESET_SEQ_STAGE_DELAY_DEFAULT = 256;
    localparam int RESET_SEQ_MAX_STAGES          = 8;

endpackage

// File: rtl/debounce.sv
// Synchronises and debounces one asynchronous level. The output follows the
// synchronised input only after the two have differed for CYCLES consecutive clocks.
module debounce
    import reset_seq_pkg::*;
#(
    parameter int   CYCLES    = RESET_SEQ_DEBOUNCE_DEFAULT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic arst_n,
    input  logic din,
    output logic dout
);

    localparam int            CW       = $clog2(CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic sync1_q;
    (* ASYNC_REG = "TRUE" *) logic sync2_q;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    // Any sample that agrees with the current output restarts the count.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sync2_q != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies clock lock (and the debounced pushbutton when RESET_SEQ_BTN_EN is
// defined), then releases the active-high reset vector one stage at a time, bit 0 first.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES      = 3,
    parameter int DEBOUNCE_CYCLES = RESET_SEQ_DEBOUNCE_DEFAULT,
    parameter int STAGE_DELAY     = RESET_SEQ_STAGE_DELAY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  locked,
    input  logic                  btn_n,
    output logic [NUM_STAGES-1:0] reset_out,
    output logic                  ready
);

    localparam int                    QW         = $clog2(DEBOUNCE_CYCLES);
    localparam int                    SW         = $clog2(STAGE_DELAY + 1);
    localparam logic [QW-1:0]         QUAL_LAST  = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0]         STAGE_LAST = SW'(STAGE_DELAY - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES   = '1;

    (* ASYNC_REG = "TRUE" *) logic locked1_q;
    (* ASYNC_REG = "TRUE" *) logic locked2_q;

    logic btn_db;
    logic qualified;

    reset_seq_state_t        state_q, state_d;
    logic [QW-1:0]           qual_q, qual_d;
    logic [SW-1:0]           stage_q, stage_d;
    logic [NUM_STAGES-1:0]   rst_q, rst_d;
    logic                    ready_q, ready_d;
    logic [NUM_STAGES-1:0]   rst_shift;

`ifdef RESET_SEQ_BTN_EN
    debounce #(
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL (1'b0)
    ) u_btn_debounce (
        .clk    (clk),
        .arst_n (arst_n),
        .din    (btn_n),
        .dout   (btn_db)
    );
`else
    logic unused_btn_n;
    assign unused_btn_n = btn_n;
    assign btn_db       = 1'b1;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            locked1_q <= 1'b0;
            locked2_q <= 1'b0;
            state_q   <= HOLD;
            qual_q    <= '0;
            stage_q   <= '0;
            rst_q     <= ALL_ONES;
            ready_q   <= 1'b0;
        end else begin
            locked1_q <= locked;
            locked2_q <= locked1_q;
            state_q   <= state_d;
            qual_q    <= qual_d;
            stage_q   <= stage_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
        end
    end

    assign qualified = locked2_q & btn_db;
    assign rst_shift = rst_q << 1;

    // Release shifts zeros in from bit 0; the vector is only ever re-asserted as a whole.
    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        ready_d = ready_q;

        case (state_q)
            HOLD: begin
                rst_d   = ALL_ONES;
                ready_d = 1'b0;
                stage_d = '0;
                if (!qualified) begin
                    qual_d = '0;
                end else if (qual_q == QUAL_LAST) begin
                    qual_d = '0;
                    rst_d  = ALL_ONES << 1;
                    if (NUM_STAGES == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    qual_d = qual_q + QW'(1);
                end
            end

            RELEASE: begin
                if (!qualified) begin
                    state_d = HOLD;
                    rst_d   = ALL_ONES;
                    ready_d = 1'b0;
                    qual_d  = '0;
                    stage_d = '0;
                end else if (stage_q == STAGE_LAST) begin
                    stage_d = '0;
                    rst_d   = rst_shift;
                    if (rst_shift == '0) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    stage_d = stage_q + SW'(1);
                end
            end

            RUN: begin
                if (!qualified) begin
                    state_d = HOLD;
                    rst_d   = ALL_ONES;
                    ready_d = 1'b0;
                    qual_d  = '0;
                    stage_d = '0;
                end
            end

            default: begin
                state_d = HOLD;
                rst_d   = ALL_ONES;
                ready_d = 1'b0;
                qual_d  = '0;
                stage_d = '0;
            end
        endcase
    end

    assign reset_out = rst_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (DEBOUNCE_CYCLES=16, STAGE_DELAY=4, NUM_STAGES=3);
// the button scenarios follow RESET_SEQ_BTN_EN.
module tb_reset_sequencer;

    localparam int N = 3;
    localparam int D = 16;
    localparam int S = 4;
`ifdef RESET_SEQ_BTN_EN
    localparam int OFF = D;
`else
    localparam int OFF = 0;
`endif

    logic         clk    = 1'b0;
    logic         arst_n = 1'b1;
    logic         locked = 1'b1;
    logic         btn_n  = 1'b1;
    logic [N-1:0] reset_out;
    logic         ready;

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES      (N),
        .DEBOUNCE_CYCLES (D),
        .STAGE_DELAY     (S)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .locked    (locked),
        .btn_n     (btn_n),
        .reset_out (reset_out),
        .ready     (ready)
    );

    // Reference: m_good is how many consecutive edges have seen lock and button qualified;
    // the expected outputs follow from that count alone.
    logic m_ls1, m_ls, m_bs1, m_bs, m_bdb;
    int   m_good, m_diff;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_ls1  <= 1'b0;
            m_ls   <= 1'b0;
            m_bs1  <= 1'b0;
            m_bs   <= 1'b0;
            m_diff <= 0;
            m_good <= 0;
`ifdef RESET_SEQ_BTN_EN
            m_bdb  <= 1'b0;
`else
            m_bdb  <= 1'b1;
`endif
        end else begin
            m_ls1  <= locked;
            m_ls   <= m_ls1;
            m_good <= (m_ls && m_bdb) ? ((m_good < 1000) ? m_good + 1 : m_good) : 0;
`ifdef RESET_SEQ_BTN_EN
            m_bs1  <= btn_n;
            m_bs   <= m_bs1;
            if (m_bs != m_bdb) begin
                if (m_diff + 1 == D) begin
                    m_bdb  <= m_bs;
                    m_diff <= 0;
                end else begin
                    m_diff <= m_diff + 1;
                end
            end else begin
                m_diff <= 0;
            end
`endif
        end
    end

    function automatic logic [N-1:0] expRst(input int good);
        int           rel;
        logic [N-1:0] ones;
        ones = '1;
        if (good < D) return ones;
        rel = 1 + (good - D) / S;
        if (rel >= N) return '0;
        return ones << rel;
    endfunction

    function automatic logic expRdy(input int good);
        return good >= D + (N - 1) * S;
    endfunction

    task automatic checkOutput(input string name, input logic [N-1:0] er, input logic erdy);
        checks++;
        if (reset_out !== er || ready !== erdy) begin
            failures++;
            $display("[TB] FAIL %s: reset_out=%b ready=%b, expected reset_out=%b ready=%b",
                     name, reset_out, ready, er, erdy);
        end
    endtask

    always @(negedge clk) begin
        if (cmpEn) checkOutput("cycle", expRst(m_good), expRdy(m_good));
    end

    // Inputs change 1 time unit after a rising edge; returns 1 unit after the n-th edge.
    task automatic applyStimulus(input logic lk, input logic bn, input int n);
        locked = lk;
        btn_n  = bn;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic powerUpPins(input string p);
        applyStimulus(1'b1, 1'b1, OFF + 17); checkOutput({p, "_e17"}, 3'b111, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);        checkOutput({p, "_e18"}, 3'b110, 1'b0);
        applyStimulus(1'b1, 1'b1, 3);        checkOutput({p, "_e21"}, 3'b110, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);        checkOutput({p, "_e22"}, 3'b100, 1'b0);
        applyStimulus(1'b1, 1'b1, 3);        checkOutput({p, "_e25"}, 3'b100, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);        checkOutput({p, "_e26"}, 3'b000, 1'b1);
    endtask

    initial begin
        logic lk, bn;
        int   n;

        #1 arst_n = 1'b0;
        cmpEn = 1'b1;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("reset_hold", 3'b111, 1'b0);
        arst_n = 1'b1;
        powerUpPins("pwrup");
        applyStimulus(1'b1, 1'b1, 5);

        // Loss of lock in RUN: two synchroniser edges, then the register edge.
        applyStimulus(1'b0, 1'b1, 2); checkOutput("fault_e2", 3'b000, 1'b1);
        applyStimulus(1'b0, 1'b1, 1); checkOutput("fault_e3", 3'b111, 1'b0);
        applyStimulus(1'b0, 1'b1, 5);

        // Requalify to qual_cnt=10, glitch lock low for 3 cycles, then qualify afresh.
        applyStimulus(1'b1, 1'b1, 12);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 17); checkOutput("glitch_e17", 3'b111, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);  checkOutput("glitch_e18", 3'b110, 1'b0);

        arst_n = 1'b0;
        #1 checkOutput("arst_async", 3'b111, 1'b0);
        applyStimulus(1'b1, 1'b1, 3);
        arst_n = 1'b1;
        powerUpPins("restart");
        applyStimulus(1'b1, 1'b1, 3);

`ifdef RESET_SEQ_BTN_EN
        repeat (3) begin
            applyStimulus(1'b1, 1'b0, 5);
            applyStimulus(1'b1, 1'b1, 5);
        end
        checkOutput("btn_bounce", 3'b000, 1'b1);
        applyStimulus(1'b1, 1'b0, 18); checkOutput("btn_hold_e18", 3'b000, 1'b1);
        applyStimulus(1'b1, 1'b0, 1);  checkOutput("btn_hold_e19", 3'b111, 1'b0);
        applyStimulus(1'b1, 1'b0, 1);
`else
        applyStimulus(1'b1, 1'b0, 20); checkOutput("btn_ignored", 3'b000, 1'b1);
`endif

        for (int i = 0; i < 60; i++) begin
            lk = ($urandom_range(0, 3) != 0);
            bn = ($urandom_range(0, 4) != 0);
            n  = $urandom_range(1, 50);
            applyStimulus(lk, bn, n);
        end

        applyStimulus(1'b1, 1'b1, OFF + 40);
        checkOutput("final_run", 3'b000, 1'b1);

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
